// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the fetch stage, BRAM port 1 and decode.
// Handshake: decode takes the head instruction in any cycle where IF_VALID and ID_READY are both 1.
interface instr_fetch_unit_if;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        ID_READY;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic [31:0] MEM_DOUT1;
    logic        IF_VALID;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        IF_ERR;
    logic [1:0]  DBG_STATE;

    modport master (
        input  REDIRECT, REDIRECT_PC, ID_READY, MEM_DOUT1,
        output MEM_ADDR1, MEM_READ1, IF_VALID, IF_INSTR, IF_PC, IF_ERR, DBG_STATE
    );

    modport slave (
        output REDIRECT, REDIRECT_PC, ID_READY, MEM_DOUT1,
        input  MEM_ADDR1, MEM_READ1, IF_VALID, IF_INSTR, IF_PC, IF_ERR, DBG_STATE
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues reads to BRAM port 1, tracks the one read in flight
// and queues returned words in a 2-entry buffer for decode; redirects flush everything.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST_N,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic        inflight_v_q, inflight_v_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic [1:0]  count_q, count_d;
    logic        err_q, err_d;

    logic        redirect_eff;
    logic        misaligned;
    logic        if_valid;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  credit;

    always_comb begin
        redirect_eff = bus.REDIRECT & (state_q != ST_BOOT);
        misaligned   = (bus.REDIRECT_PC[1:0] != 2'b00);
        if_valid     = (count_q != 2'd0) & (state_q != ST_HALT);
        pop          = if_valid & bus.ID_READY;
        push         = inflight_v_q & ~redirect_eff;
        // Slots that will still be occupied after this edge's pop; one free slot allows a new read.
        credit       = {1'b0, count_q} + {2'b00, inflight_v_q} - {2'b00, pop};
        issue        = (state_q == ST_RUN) & ~bus.REDIRECT & (credit <= 3'd1);
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (redirect_eff && misaligned) state_d = ST_HALT;
            ST_HALT: if (redirect_eff && !misaligned) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
        if (redirect_eff) err_d = misaligned;
    end

    always_comb begin
        fpc_d         = fpc_q;
        inflight_v_d  = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_eff) begin
            fpc_d = bus.REDIRECT_PC;
        end else if (issue) begin
            fpc_d         = fpc_q + 32'd4;
            inflight_pc_d = fpc_q;
        end
    end

    always_comb begin
        count_d        = count_q;
        buf_pc_d[0]    = buf_pc_q[0];
        buf_pc_d[1]    = buf_pc_q[1];
        buf_instr_d[0] = buf_instr_q[0];
        buf_instr_d[1] = buf_instr_q[1];
        if (redirect_eff) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        buf_pc_d[0]    = inflight_pc_q;
                        buf_instr_d[0] = bus.MEM_DOUT1;
                    end else begin
                        buf_pc_d[1]    = inflight_pc_q;
                        buf_instr_d[1] = bus.MEM_DOUT1;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    buf_pc_d[0]    = buf_pc_q[1];
                    buf_instr_d[0] = buf_instr_q[1];
                    count_d        = count_q - 2'd1;
                end
                2'b11: begin
                    // Head leaves; the arriving word lands behind whatever remains.
                    if (count_q == 2'd2) begin
                        buf_pc_d[0]    = buf_pc_q[1];
                        buf_instr_d[0] = buf_instr_q[1];
                        buf_pc_d[1]    = inflight_pc_q;
                        buf_instr_d[1] = bus.MEM_DOUT1;
                    end else begin
                        buf_pc_d[0]    = inflight_pc_q;
                        buf_instr_d[0] = bus.MEM_DOUT1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_BOOT;
            fpc_q         <= RESET_VEC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= 32'd0;
            count_q       <= 2'd0;
            err_q         <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]    <= 32'd0;
                buf_instr_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            err_q         <= err_d;
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]    <= buf_pc_d[i];
                buf_instr_q[i] <= buf_instr_d[i];
            end
        end
    end

    assign bus.MEM_ADDR1 = fpc_q;
    assign bus.MEM_READ1 = issue;
    assign bus.IF_VALID  = if_valid;
    assign bus.IF_INSTR  = buf_instr_q[0];
    assign bus.IF_PC     = buf_pc_q[0];
    assign bus.IF_ERR    = err_q;
    assign bus.DBG_STATE = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: BRAM model, stream-level reference model checked every cycle,
// and directed timing checks for boot, stall, redirect, misaligned halt, PC wrap and reset.
module tb_instr_fetch_unit;
    logic CLK;
    logic RST_N;
    int   n_checks;
    int   n_fail;
    int   cyc;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_VEC(32'h0000_0000)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.master)
    );

    // clock / reset / cycle counter
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0000_1000 + (addr >> 2);
    endfunction

    // BRAM port 1: one-cycle registered read
    always @(posedge CLK) begin
        if (bus.MEM_READ1) bus.MEM_DOUT1 <= mem_word(bus.MEM_ADDR1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%h req=%h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    // reference model: expected delivery order and issue order, with credit bound
    logic [31:0] m_pop_pc;
    logic [31:0] m_issue_pc;
    logic        m_err;
    int          m_outstanding;
    logic [31:0] exp_q[$];

    always @(negedge CLK) begin
        if (!RST_N) begin
            m_pop_pc      = 32'h0;
            m_issue_pc    = 32'h0;
            m_err         = 1'b0;
            m_outstanding = 0;
            exp_q.delete();
        end else begin
            if (cyc == 0) check("boot_no_issue", {31'b0, bus.MEM_READ1}, 32'd0);
            if (bus.REDIRECT) check("no_issue_on_redirect", {31'b0, bus.MEM_READ1}, 32'd0);
            check("err_flag", {31'b0, bus.IF_ERR}, {31'b0, m_err});
            if (m_err) begin
                check("halt_no_valid", {31'b0, bus.IF_VALID}, 32'd0);
                check("halt_no_issue", {31'b0, bus.MEM_READ1}, 32'd0);
            end
            if (bus.MEM_READ1) begin
                check("issue_addr", bus.MEM_ADDR1, m_issue_pc);
                exp_q.push_back(m_issue_pc);
                m_issue_pc    = m_issue_pc + 32'd4;
                m_outstanding = m_outstanding + 1;
            end
            if (bus.IF_VALID && bus.ID_READY) begin
                check("stream_pc", bus.IF_PC, m_pop_pc);
                check("stream_instr", bus.IF_INSTR, mem_word(m_pop_pc));
                if (exp_q.size() == 0) check("pop_without_issue", 32'd1, 32'd0);
                else void'(exp_q.pop_front());
                m_pop_pc      = m_pop_pc + 32'd4;
                m_outstanding = m_outstanding - 1;
            end
            if (m_outstanding > 2) check("credit_bound", m_outstanding, 32'd2);
            if (bus.REDIRECT && cyc != 0) begin
                m_pop_pc      = bus.REDIRECT_PC;
                m_issue_pc    = bus.REDIRECT_PC;
                m_outstanding = 0;
                m_err         = (bus.REDIRECT_PC[1:0] != 2'b00);
                exp_q.delete();
            end
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        next_cycle();
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = pc;
        @(negedge CLK);
        check("redirect_cycle_no_issue", {31'b0, bus.MEM_READ1}, 32'd0);
        next_cycle();
        bus.REDIRECT = 1'b0;
    endtask

    task automatic first_fetch_timing();
        @(negedge CLK);
        check("c0_read", {31'b0, bus.MEM_READ1}, 32'd0);
        @(negedge CLK);
        check("c1_read", {31'b0, bus.MEM_READ1}, 32'd1);
        check("c1_addr", bus.MEM_ADDR1, 32'h0);
        @(negedge CLK);
        check("c2_valid", {31'b0, bus.IF_VALID}, 32'd0);
        @(negedge CLK);
        check("c3_valid", {31'b0, bus.IF_VALID}, 32'd1);
        check("c3_pc", bus.IF_PC, 32'h0);
        check("c3_instr", bus.IF_INSTR, 32'h0000_1000);
    endtask

    logic [15:0] pat;

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        RST_N           = 1'b0;
        bus.REDIRECT    = 1'b0;
        bus.REDIRECT_PC = 32'h0;
        bus.ID_READY    = 1'b1;
        bus.MEM_DOUT1   = 32'hDEAD_BEEF;
        pat             = 16'b1011_0010_1110_0101;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_valid", {31'b0, bus.IF_VALID}, 32'd0);
        check("rst_read", {31'b0, bus.MEM_READ1}, 32'd0);
        check("rst_err", {31'b0, bus.IF_ERR}, 32'd0);
        check("rst_addr", bus.MEM_ADDR1, 32'h0);

        next_cycle();
        RST_N = 1'b1;
        first_fetch_timing();
        @(negedge CLK);
        check("c4_pc", bus.IF_PC, 32'h4);
        check("c4_instr", bus.IF_INSTR, 32'h0000_1001);
        @(negedge CLK);
        check("c5_pc", bus.IF_PC, 32'h8);
        check("c5_instr", bus.IF_INSTR, 32'h0000_1002);

        // decode stall for 5 cycles
        next_cycle();
        bus.ID_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_read", {31'b0, bus.MEM_READ1}, 32'd0);
            check("stall_head", bus.IF_PC, 32'hC);
            check("stall_valid", {31'b0, bus.IF_VALID}, 32'd1);
        end
        next_cycle();
        bus.ID_READY = 1'b1;
        @(negedge CLK);
        check("resume_pc0", bus.IF_PC, 32'hC);
        check("resume_read", {31'b0, bus.MEM_READ1}, 32'd1);
        @(negedge CLK);
        check("resume_pc1", bus.IF_PC, 32'h10);
        @(negedge CLK);
        check("resume_pc2", bus.IF_PC, 32'h14);

        // redirect with one entry buffered, one read in flight, decode stalled
        next_cycle();
        bus.ID_READY    = 1'b0;
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'h40;
        @(negedge CLK);
        check("redir_no_issue", {31'b0, bus.MEM_READ1}, 32'd0);
        next_cycle();
        bus.REDIRECT = 1'b0;
        bus.ID_READY = 1'b1;
        @(negedge CLK);
        check("redir_r1_read", {31'b0, bus.MEM_READ1}, 32'd1);
        check("redir_r1_addr", bus.MEM_ADDR1, 32'h40);
        check("redir_r1_valid", {31'b0, bus.IF_VALID}, 32'd0);
        @(negedge CLK);
        check("redir_r2_valid", {31'b0, bus.IF_VALID}, 32'd0);
        @(negedge CLK);
        check("redir_r3_valid", {31'b0, bus.IF_VALID}, 32'd1);
        check("redir_r3_pc", bus.IF_PC, 32'h40);
        check("redir_r3_instr", bus.IF_INSTR, 32'h0000_1010);

        // misaligned target halts fetch
        redirect_to(32'h42);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("mis_err", {31'b0, bus.IF_ERR}, 32'd1);
            check("mis_valid", {31'b0, bus.IF_VALID}, 32'd0);
            check("mis_read", {31'b0, bus.MEM_READ1}, 32'd0);
            if (i < 2) next_cycle();
        end
        redirect_to(32'h80);
        @(negedge CLK);
        check("recover_err", {31'b0, bus.IF_ERR}, 32'd0);
        check("recover_read", {31'b0, bus.MEM_READ1}, 32'd1);
        check("recover_addr", bus.MEM_ADDR1, 32'h80);
        @(negedge CLK);
        @(negedge CLK);
        check("recover_valid", {31'b0, bus.IF_VALID}, 32'd1);
        check("recover_pc", bus.IF_PC, 32'h80);
        check("recover_instr", bus.IF_INSTR, 32'h0000_1020);

        // PC wrap at the top of the address space
        redirect_to(32'hFFFF_FFF8);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        check("wrap_pc0", bus.IF_PC, 32'hFFFF_FFF8);
        check("wrap_instr0", bus.IF_INSTR, 32'h4000_0FFE);
        @(negedge CLK);
        check("wrap_pc1", bus.IF_PC, 32'hFFFF_FFFC);
        check("wrap_instr1", bus.IF_INSTR, 32'h4000_0FFF);
        @(negedge CLK);
        check("wrap_pc2", bus.IF_PC, 32'h0);
        check("wrap_instr2", bus.IF_INSTR, 32'h0000_1000);
        @(negedge CLK);
        check("wrap_pc3", bus.IF_PC, 32'h4);

        // asynchronous reset mid-stream
        next_cycle();
        RST_N = 1'b0;
        #1;
        check("midrst_valid", {31'b0, bus.IF_VALID}, 32'd0);
        check("midrst_read", {31'b0, bus.MEM_READ1}, 32'd0);
        check("midrst_addr", bus.MEM_ADDR1, 32'h0);
        next_cycle();
        RST_N = 1'b1;
        first_fetch_timing();

        // irregular decode back-pressure; the stream model checks ordering
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            bus.ID_READY = pat[i];
        end
        next_cycle();
        bus.ID_READY = 1'b1;
        repeat (6) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
